// File: rtl/cpu_pc_gen.sv
// Program-counter generation: sequential stepping, branch/flush redirects and
// a single pending-redirect slot that carries a branch across a pipeline stall.
module cpu_pc_gen #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        pc_valid,
  output logic        addr_err,
  output logic        branch_pending
);

  logic [31:0] pc_reg, pc_next;
  logic        pc_valid_reg, pc_valid_next;
  logic        pend_reg, pend_next;
  logic [31:0] pend_target_reg, pend_target_next;

  // The edge that first raises pc_valid only validates RESET_PC, so the boot
  // vector is fetched before any stepping or redirect takes effect.
  always_comb begin
    pc_next          = pc_reg;
    pc_valid_next    = 1'b1;
    pend_next        = pend_reg;
    pend_target_next = pend_target_reg;

    if (!pc_valid_reg) begin
      pc_next = pc_reg;
    end else if (flush) begin
      pc_next   = flush_pc;
      pend_next = 1'b0;
    end else if (stall) begin
      if (branch_flag) begin
        pend_next        = 1'b1;
        pend_target_next = branch_target;
      end
    end else if (branch_flag) begin
      pc_next   = branch_target;
      pend_next = 1'b0;
    end else if (pend_reg) begin
      pc_next   = pend_target_reg;
      pend_next = 1'b0;
    end else begin
      pc_next = pc_reg + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= RESET_PC;
      pc_valid_reg    <= 1'b0;
      pend_reg        <= 1'b0;
      pend_target_reg <= 32'h0000_0000;
    end else begin
      pc_reg          <= pc_next;
      pc_valid_reg    <= pc_valid_next;
      pend_reg        <= pend_next;
      pend_target_reg <= pend_target_next;
    end
  end

  // A misaligned pc is only flagged; recovery is left to CP0 via flush.
  assign pc             = pc_reg;
  assign pc_valid       = pc_valid_reg;
  assign addr_err       = pc_valid_reg & (pc_reg[1:0] != 2'b00);
  assign branch_pending = pend_reg;

endmodule

// File: tb/tb_cpu_pc_gen.sv
// Directed bench for cpu_pc_gen: each task drives one scenario and checks the
// registered outputs 1 ns after the clock edge against hand-computed values.
module tb_cpu_pc_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] pc;
  logic        pc_valid;
  logic        addr_err;
  logic        branch_pending;

  int n_cmp = 0;
  int n_err = 0;

  cpu_pc_gen dut (
    .clk(clk),
    .rst(rst),
    .stall(stall),
    .flush(flush),
    .flush_pc(flush_pc),
    .branch_flag(branch_flag),
    .branch_target(branch_target),
    .pc(pc),
    .pc_valid(pc_valid),
    .addr_err(addr_err),
    .branch_pending(branch_pending)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b stall=%b flush=%b bf=%b -> pc=%08h valid=%b err=%b pend=%b",
             $time, rst, stall, flush, branch_flag, pc, pc_valid, addr_err, branch_pending);
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL reset_pc got %08h want BFC00000", pc); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b want 0", pc_valid); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL reset_pend got %b want 0", branch_pending); end
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL reset_err got %b want 0", addr_err); end
    rst = 1'b0;
    step();
    n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL first_pc got %08h want BFC00000", pc); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL first_valid got %b want 1", pc_valid); end
  endtask

  task automatic test_sequential();
    step();
    n_cmp++; if (pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL seq1 got %08h want BFC00004", pc); end
    step();
    n_cmp++; if (pc !== 32'hBFC0_0008) begin n_err++; $display("FAIL seq2 got %08h want BFC00008", pc); end
    step();
    n_cmp++; if (pc !== 32'hBFC0_000C) begin n_err++; $display("FAIL seq3 got %08h want BFC0000C", pc); end
  endtask

  task automatic test_stall_branch();
    stall = 1'b1;
    step();
    n_cmp++; if (pc !== 32'hBFC0_000C) begin n_err++; $display("FAIL stall_hold1 got %08h want BFC0000C", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL stall_pend0 got %b want 0", branch_pending); end
    branch_flag = 1'b1; branch_target = 32'h8000_1000;
    step();
    n_cmp++; if (pc !== 32'hBFC0_000C) begin n_err++; $display("FAIL stall_hold2 got %08h want BFC0000C", pc); end
    n_cmp++; if (branch_pending !== 1'b1) begin n_err++; $display("FAIL stall_pend1 got %b want 1", branch_pending); end
    branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'hBFC0_000C) begin n_err++; $display("FAIL stall_hold3 got %08h want BFC0000C", pc); end
    n_cmp++; if (branch_pending !== 1'b1) begin n_err++; $display("FAIL stall_pend2 got %b want 1", branch_pending); end
    stall = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_1000) begin n_err++; $display("FAIL pend_apply got %08h want 80001000", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL pend_clear got %b want 0", branch_pending); end
    step();
    n_cmp++; if (pc !== 32'h8000_1004) begin n_err++; $display("FAIL pend_after got %08h want 80001004", pc); end
  endtask

  task automatic test_back_to_back();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_1000;
    step();
    branch_target = 32'h8000_2000;
    step();
    stall = 1'b0; branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_2000) begin n_err++; $display("FAIL latest_wins got %08h want 80002000", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL latest_clear got %b want 0", branch_pending); end
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_1000;
    step();
    n_cmp++; if (branch_pending !== 1'b1) begin n_err++; $display("FAIL direct_pend got %b want 1", branch_pending); end
    stall = 1'b0; branch_target = 32'h8000_3000;
    step();
    n_cmp++; if (pc !== 32'h8000_3000) begin n_err++; $display("FAIL direct_beats got %08h want 80003000", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL direct_clear got %b want 0", branch_pending); end
    branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_3004) begin n_err++; $display("FAIL direct_after got %08h want 80003004", pc); end
  endtask

  task automatic test_flush();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_1000;
    flush = 1'b1; flush_pc = 32'h8000_0180;
    step();
    n_cmp++; if (pc !== 32'h8000_0180) begin n_err++; $display("FAIL flush_pc got %08h want 80000180", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL flush_pend got %b want 0", branch_pending); end
    stall = 1'b0; branch_flag = 1'b0; flush = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_0184) begin n_err++; $display("FAIL flush_after got %08h want 80000184", pc); end
    // A redirect already pending must also be dropped by a flush.
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_4000;
    step();
    n_cmp++; if (branch_pending !== 1'b1) begin n_err++; $display("FAIL flush2_pre got %b want 1", branch_pending); end
    branch_flag = 1'b0; flush = 1'b1; flush_pc = 32'h8000_0200;
    step();
    n_cmp++; if (pc !== 32'h8000_0200) begin n_err++; $display("FAIL flush2_pc got %08h want 80000200", pc); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL flush2_pend got %b want 0", branch_pending); end
    flush = 1'b0; stall = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_0204) begin n_err++; $display("FAIL flush2_after got %08h want 80000204", pc); end
  endtask

  task automatic test_misalign_wrap();
    branch_flag = 1'b1; branch_target = 32'h8000_0002;
    step();
    n_cmp++; if (pc !== 32'h8000_0002) begin n_err++; $display("FAIL mis_pc got %08h want 80000002", pc); end
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL mis_err got %b want 1", addr_err); end
    branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h8000_0006) begin n_err++; $display("FAIL mis_step got %08h want 80000006", pc); end
    n_cmp++; if (addr_err !== 1'b1) begin n_err++; $display("FAIL mis_err2 got %b want 1", addr_err); end
    flush = 1'b1; flush_pc = 32'h8000_0180;
    step();
    n_cmp++; if (addr_err !== 1'b0) begin n_err++; $display("FAIL mis_recover got %b want 0", addr_err); end
    flush_pc = 32'hFFFF_FFFC;
    step();
    n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_pre got %08h want FFFFFFFC", pc); end
    flush = 1'b0;
    step();
    n_cmp++; if (pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap got %08h want 00000000", pc); end
    step();
    n_cmp++; if (pc !== 32'h0000_0004) begin n_err++; $display("FAIL wrap_after got %08h want 00000004", pc); end
  endtask

  task automatic test_reset_pending();
    stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h8000_5000;
    step();
    n_cmp++; if (branch_pending !== 1'b1) begin n_err++; $display("FAIL rstp_pre got %b want 1", branch_pending); end
    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0;
    step();
    n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rstp_pc got %08h want BFC00000", pc); end
    n_cmp++; if (pc_valid !== 1'b0) begin n_err++; $display("FAIL rstp_valid got %b want 0", pc_valid); end
    n_cmp++; if (branch_pending !== 1'b0) begin n_err++; $display("FAIL rstp_pend got %b want 0", branch_pending); end
    rst = 1'b0;
    step();
    n_cmp++; if (pc !== 32'hBFC0_0000) begin n_err++; $display("FAIL rstp_boot got %08h want BFC00000", pc); end
    n_cmp++; if (pc_valid !== 1'b1) begin n_err++; $display("FAIL rstp_valid1 got %b want 1", pc_valid); end
    step();
    n_cmp++; if (pc !== 32'hBFC0_0004) begin n_err++; $display("FAIL rstp_noapply got %08h want BFC00004", pc); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall_branch();
    test_back_to_back();
    test_flush();
    test_misalign_wrap();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
